i2c_master_burst_ctrl: RTL and testbench
========================================

# i2c_master_burst_ctrl

Parametrised multi-byte I2C master controller. It sits between the APB register file and the I2C bit controller, and turns one host command (optional START, N bytes of WRITE or READ, optional STOP) into the bit-level command sequence. Per-byte ACK handling is built in: master ACK/NACK generation on reads, slave-NACK abort on writes. Arbitration-loss recovery is also built in. The host handshakes once per burst, not once per byte.

## Interface
Parameters:
- MAX_BYTES, default 4: maximum bytes per burst, legal range 1..8.
- ABORT_ON_NACK, default 1: 1 = a slave NACK during a write ends the burst early; 0 = the remaining bytes are still sent.
- LW (localparam) = $clog2(MAX_BYTES+1): width of the length fields.

Ports:
- clk  in  1  master clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- ena  in  1  core enable. No new burst is accepted while ena=0; a burst in flight completes.
- start  in  1  issue START (or repeated START) before the data bytes.
- stop  in  1  issue STOP after the data bytes.
- read  in  1  read burst.
- write  in  1  write burst.
- ack_in  in  1  ACK bit the master drives after the last read byte (1 = NACK).
- len  in  LW  byte count. 0 is treated as 1; values above MAX_BYTES clamp to MAX_BYTES.
- din  in  8*MAX_BYTES  write data. Byte k is din[8k+7:8k]; byte 0 goes first; bits MSB first.
- dout  out  8*MAX_BYTES  read data, same byte mapping as din.
- cmd_ack  out  1  one-cycle pulse: burst finished.
- ack_out  out  1  core_rxd sampled at the last ACK phase executed.
- nack  out  1  the write burst was ended by a slave NACK. Valid with cmd_ack.
- byte_cnt  out  LW  number of bytes whose ACK phase completed. Valid with cmd_ack.
- busy  out  1  high from burst acceptance until cmd_ack, or until abort.
- core_cmd  out  4  bit-controller command: NOP=0000, START=0001, STOP=0010, WRITE=0100, READ=1000.
- core_txd  out  1  bit value for WRITE commands.
- core_ack  in  1  bit controller done. Single-cycle pulse.
- core_rxd  in  1  received bit. Valid in the core_ack cycle.
- i2c_al  in  1  arbitration lost.

## Operation
- Burst acceptance:
  - go = ena & (read|write|stop) & ~cmd_ack, evaluated in IDLE.
  - On go, the block latches len (after clamping), din, the read/write choice and the stop flag. It also clears dout (read burst only), byte_cnt and nack.
- States: IDLE, START, WBIT, WACK, RBIT, RACK, STOP.
- Transitions out of IDLE on go:
  - start=1 → START.
  - else read=1 → RBIT.
  - else write=1 → WBIT.
  - else → STOP (stop-only burst).
- Transitions on core_ack in each state:
  - START → RBIT if read, otherwise WBIT.
  - WBIT: repeats for 8 bits, then → WACK (issues READ).
  - WACK:
    - Samples core_rxd into ack_out and increments byte_cnt.
    - If core_rxd=1 and ABORT_ON_NACK=1: sets nack, then → STOP if stop, else → IDLE.
    - Else if more bytes remain → WBIT.
    - Else → STOP if stop, else → IDLE.
  - RBIT: shifts core_rxd in for 8 bits, then → RACK (issues WRITE). The completed byte is written to dout byte byte_cnt.
  - RACK:
    - core_txd = 0 (ACK) for every byte except the last; for the last byte, core_txd = ack_in.
    - Samples core_rxd into ack_out and increments byte_cnt.
    - Next state: → RBIT if more bytes remain, else → STOP if stop, else → IDLE.
  - STOP → IDLE.
- cmd_ack pulses exactly once per burst, on the transition into IDLE.
- Arbitration loss: i2c_al=1 in any cycle forces IDLE at the next edge.
  - core_cmd is set to NOP and busy to 0.
  - No cmd_ack is generated; the host observes i2c_al directly.
  - dout, byte_cnt and nack keep their partial values.

## Timing
- Reset values:
  - core_cmd=NOP.
  - cmd_ack, ack_out, nack, busy, core_txd all 0.
  - byte_cnt=0, dout=0.
  - State IDLE.
- core_cmd and core_txd are registered:
  - Both take effect one cycle after go, or one cycle after core_ack.
  - Both are held stable until the next core_ack.
  - core_txd is valid in the same cycle as its WRITE command.
- Between consecutive bit commands, core_cmd stays at the next command and is never NOP.
- cmd_ack is asserted in the cycle after the final core_ack. busy falls in the same cycle.
- The earliest new go is accepted in the cycle after cmd_ack.
- Simultaneous core_ack and i2c_al: abort wins.
- Command inputs that change while busy are ignored. stop and ack_in are the exceptions: they are sampled live at the final ACK phase.
- Burst duration in bit-controller commands: [start] + 9*len + [stop].

## Test plan
- Reset: assert rst mid-WBIT → all outputs at reset values, core_cmd=NOP; after release, a new burst runs normally.
- Write burst: start=1, write=1, stop=1, len=3, din=0xA55A3C, slave ACKs every byte → bit order on core_txd is 3C, 5A, A5 (MSB first); byte_cnt=3, nack=0, ack_out=0; sequence ends with STOP and a single cmd_ack.
- Write NACK: same burst, slave NACKs byte 1, ABORT_ON_NACK=1 → byte 2 not sent, STOP issued, nack=1, byte_cnt=2, ack_out=1.
- Read burst: read=1, len=2, ack_in=1, no stop, slave bits 0x81 then 0x7E → dout[15:0]=0x7E81; master ACK bit 0 after byte 0 and 1 after byte 1; no STOP; cmd_ack pulses.
- Arbitration loss: i2c_al pulsed during RBIT bit 4 → IDLE next cycle, core_cmd=NOP, no cmd_ack; the next stop-only burst gives exactly STOP then cmd_ack.
- len boundary: len=0 → exactly 1 byte transferred; len=7 with MAX_BYTES=4 → exactly 4 bytes, byte_cnt=4.

Source files
------------

// File: rtl/i2c_master_burst_ctrl.sv
// i2c_master_burst_ctrl: multi-byte I2C master burst sequencer.
// Turns one host command (START, N bytes WR/RD, STOP) into bit-level commands.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   ena                  core enable; gates acceptance of new bursts
//   start/stop/read/write/ack_in/len/din   host burst command
//   dout, cmd_ack, ack_out, nack, byte_cnt, busy   host status
//   core_cmd, core_txd   bit-controller command and write bit
//   core_ack, core_rxd   bit-controller done pulse and received bit
//   i2c_al               arbitration lost
module i2c_master_burst_ctrl #(
  parameter int MAX_BYTES     = 4,
  parameter int ABORT_ON_NACK = 1,
  localparam int LW = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   read,
  input  logic                   write,
  input  logic                   ack_in,
  input  logic [LW-1:0]          len,
  input  logic [8*MAX_BYTES-1:0] din,
  output logic [8*MAX_BYTES-1:0] dout,
  output logic                   cmd_ack,
  output logic                   ack_out,
  output logic                   nack,
  output logic [LW-1:0]          byte_cnt,
  output logic                   busy,
  output logic [3:0]             core_cmd,
  output logic                   core_txd,
  input  logic                   core_ack,
  input  logic                   core_rxd,
  input  logic                   i2c_al
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WBIT,
    S_WACK,
    S_RBIT,
    S_RACK,
    S_STOP
  } state_t;

  state_t state, state_n;

  logic [LW-1:0]          len_q;
  logic [LW-1:0]          len_c;
  logic [8*MAX_BYTES-1:0] wdat;
  logic [8*MAX_BYTES-1:0] wnext;
  logic [7:0]             rsh;
  logic [2:0]             bit_cnt;
  logic                   rd_q;

  logic       go;
  logic       last;
  logic       bit_last;
  logic       nack_hit;
  logic       fin;
  logic [3:0] cmd_n;
  logic       txd_n;
  logic       cmd_ack_n;
  logic       busy_n;

  assign go = (state == S_IDLE) & ena
            & (read | write | stop) & ~cmd_ack;

  assign len_c = (len == '0) ? LW'(1) :
                 (len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : len;

  // Current byte is the one at index byte_cnt (not yet counted).
  assign last     = LW'(byte_cnt + LW'(1)) == len_q;
  assign bit_last = bit_cnt == 3'd7;
  assign nack_hit = core_rxd && (ABORT_ON_NACK != 0);
  // Write data is consumed a byte at a time from the low end.
  assign wnext    = wdat >> 8;

  always_comb begin
    state_n   = state;
    cmd_n     = core_cmd;
    txd_n     = core_txd;
    cmd_ack_n = 1'b0;
    busy_n    = busy;
    fin       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          busy_n = 1'b1;
          if (start) begin
            state_n = S_START;
            cmd_n   = CMD_START;
          end else if (read) begin
            state_n = S_RBIT;
            cmd_n   = CMD_READ;
          end else if (write) begin
            state_n = S_WBIT;
            cmd_n   = CMD_WRITE;
            txd_n   = din[7];
          end else begin
            state_n = S_STOP;
            cmd_n   = CMD_STOP;
          end
        end
      end
      S_START: begin
        if (core_ack) begin
          if (rd_q) begin
            state_n = S_RBIT;
            cmd_n   = CMD_READ;
          end else begin
            state_n = S_WBIT;
            cmd_n   = CMD_WRITE;
            txd_n   = wdat[7];
          end
        end
      end
      S_WBIT: begin
        if (core_ack) begin
          if (bit_last) begin
            state_n = S_WACK;
            cmd_n   = CMD_READ;
          end else begin
            cmd_n = CMD_WRITE;
            // wdat[7:0] rotates left each bit, so [6] is next.
            txd_n = wdat[6];
          end
        end
      end
      S_WACK: begin
        if (core_ack) begin
          if (nack_hit || last) begin
            fin = 1'b1;
          end else begin
            state_n = S_WBIT;
            cmd_n   = CMD_WRITE;
            txd_n   = wnext[7];
          end
        end
      end
      S_RBIT: begin
        if (core_ack) begin
          if (bit_last) begin
            state_n = S_RACK;
            cmd_n   = CMD_WRITE;
            txd_n   = last ? ack_in : 1'b0;
          end else begin
            cmd_n = CMD_READ;
          end
        end
      end
      S_RACK: begin
        if (core_ack) begin
          if (last) begin
            fin = 1'b1;
          end else begin
            state_n = S_RBIT;
            cmd_n   = CMD_READ;
          end
        end
      end
      S_STOP: begin
        if (core_ack) begin
          state_n   = S_IDLE;
          cmd_n     = CMD_NOP;
          cmd_ack_n = 1'b1;
          busy_n    = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
        cmd_n   = CMD_NOP;
        busy_n  = 1'b0;
      end
    endcase

    // stop is sampled live at the final ACK phase.
    if (fin) begin
      if (stop) begin
        state_n = S_STOP;
        cmd_n   = CMD_STOP;
      end else begin
        state_n   = S_IDLE;
        cmd_n     = CMD_NOP;
        cmd_ack_n = 1'b1;
        busy_n    = 1'b0;
      end
    end

    if (i2c_al) begin
      state_n   = S_IDLE;
      cmd_n     = CMD_NOP;
      cmd_ack_n = 1'b0;
      busy_n    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      core_cmd <= CMD_NOP;
      core_txd <= 1'b0;
      cmd_ack  <= 1'b0;
      busy     <= 1'b0;
      ack_out  <= 1'b0;
      nack     <= 1'b0;
      byte_cnt <= '0;
      dout     <= '0;
      len_q    <= '0;
      wdat     <= '0;
      rsh      <= '0;
      bit_cnt  <= '0;
      rd_q     <= 1'b0;
    end else begin
      state    <= state_n;
      core_cmd <= cmd_n;
      core_txd <= txd_n;
      cmd_ack  <= cmd_ack_n;
      busy     <= busy_n;
      if (!i2c_al) begin
        if (go) begin
          len_q    <= len_c;
          wdat     <= din;
          rd_q     <= read;
          byte_cnt <= '0;
          nack     <= 1'b0;
          bit_cnt  <= '0;
          if (read) dout <= '0;
        end
        if (core_ack) begin
          unique case (state)
            S_WBIT: begin
              bit_cnt   <= bit_cnt + 3'd1;
              wdat[7:0] <= {wdat[6:0], wdat[7]};
            end
            S_WACK: begin
              ack_out  <= core_rxd;
              byte_cnt <= byte_cnt + LW'(1);
              wdat     <= wnext;
              if (nack_hit) nack <= 1'b1;
            end
            S_RBIT: begin
              bit_cnt <= bit_cnt + 3'd1;
              rsh     <= {rsh[6:0], core_rxd};
              if (bit_last) begin
                for (int k = 0; k < MAX_BYTES; k++) begin
                  if (byte_cnt == LW'(k))
                    dout[8*k +: 8] <= {rsh[6:0], core_rxd};
                end
              end
            end
            S_RACK: begin
              ack_out  <= core_rxd;
              byte_cnt <= byte_cnt + LW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_burst_ctrl.sv
// tb_i2c_master_burst_ctrl: directed bench for i2c_master_burst_ctrl.
// A bit-controller model acks each command and logs {cmd, txd}.
module tb_i2c_master_burst_ctrl;

  localparam int MB = 4;
  localparam int LW = $clog2(MB + 1);

  localparam logic [3:0] NOP   = 4'b0000;
  localparam logic [3:0] START = 4'b0001;
  localparam logic [3:0] STOP  = 4'b0010;
  localparam logic [3:0] WR    = 4'b0100;
  localparam logic [3:0] RD    = 4'b1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic          ack_in = 1'b0;
  logic [LW-1:0] len = '0;
  logic [8*MB-1:0] din = '0;
  logic [8*MB-1:0] dout;
  logic          cmd_ack;
  logic          ack_out;
  logic          nack;
  logic [LW-1:0] byte_cnt;
  logic          busy;
  logic [3:0]    core_cmd;
  logic          core_txd;
  logic          core_ack = 1'b0;
  logic          core_rxd = 1'b0;
  logic          i2c_al = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [3:0] logc[$];
  logic       logt[$];
  logic       rxq[$];
  int         wcnt = 0;

  i2c_master_burst_ctrl #(
    .MAX_BYTES(MB),
    .ABORT_ON_NACK(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .start(start),
    .stop(stop),
    .read(read),
    .write(write),
    .ack_in(ack_in),
    .len(len),
    .din(din),
    .dout(dout),
    .cmd_ack(cmd_ack),
    .ack_out(ack_out),
    .nack(nack),
    .byte_cnt(byte_cnt),
    .busy(busy),
    .core_cmd(core_cmd),
    .core_txd(core_txd),
    .core_ack(core_ack),
    .core_rxd(core_rxd),
    .i2c_al(i2c_al)
  );

  always #5 clk = ~clk;

  // Bit-controller model: acks every command after a short delay.
  // READ returns the next queued slave bit; WRITE echoes the bus bit.
  initial begin : responder
    forever begin
      @(negedge clk);
      if (core_ack) begin
        core_ack = 1'b0;
      end else if (core_cmd == NOP || rst) begin
        wcnt = 0;
      end else begin
        wcnt++;
        if (wcnt == 2) begin
          wcnt = 0;
          logc.push_back(core_cmd);
          logt.push_back(core_txd);
          if (core_cmd == RD)
            core_rxd = (rxq.size() > 0) ? rxq.pop_front() : 1'b0;
          else if (core_cmd == WR)
            core_rxd = core_txd;
          else
            core_rxd = 1'b0;
          core_ack = 1'b1;
        end
      end
    end
  end

  task automatic launch(input logic s, input logic p, input logic r,
                        input logic w, input logic ai,
                        input logic [LW-1:0] ln,
                        input logic [8*MB-1:0] d);
    @(negedge clk);
    logc.delete();
    logt.delete();
    ena = 1'b1;
    start = s;
    stop = p;
    read = r;
    write = w;
    ack_in = ai;
    len = ln;
    din = d;
    @(negedge clk);
    start = 1'b0;
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic wait_done(output bit ok, output int pulses,
                           output logic busy_at_ack);
    ok = 1'b0;
    pulses = 0;
    busy_at_ack = 1'bx;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ack) begin
        ok = 1'b1;
        pulses++;
        busy_at_ack = busy;
        stop = 1'b0;
        break;
      end
    end
    repeat (8) begin
      @(negedge clk);
      if (cmd_ack) pulses++;
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    checks++;
    if (core_cmd !== NOP || busy !== 1'b0 || cmd_ack !== 1'b0 ||
        ack_out !== 1'b0 || nack !== 1'b0 || core_txd !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: cmd=%b busy=%b ack=%b aout=%b nack=%b txd=%b",
               core_cmd, busy, cmd_ack, ack_out, nack, core_txd);
    end
    checks++;
    if (byte_cnt !== '0 || dout !== '0) begin
      errors++;
      $display("FAIL reset_data: byte_cnt=%0d dout=%h want 0/0",
               byte_cnt, dout);
    end
    rst = 1'b0;
    launch(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, LW'(2), 32'h0000_12F4);
    n = 0;
    while (logc.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (core_cmd !== WR || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_midburst: cmd=%b busy=%b want 0100/1",
               core_cmd, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (core_cmd !== NOP || busy !== 1'b0 || core_txd !== 1'b0 ||
        cmd_ack !== 1'b0 || byte_cnt !== '0 || nack !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: cmd=%b busy=%b txd=%b ack=%b cnt=%0d nack=%b",
               core_cmd, busy, core_txd, cmd_ack, byte_cnt, nack);
    end
    @(negedge clk);
    rst = 1'b0;
    stop = 1'b0;
    rxq.delete();
    repeat (5) @(negedge clk);
    checks++;
    if (core_cmd !== NOP || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_after: cmd=%b busy=%b want 0000/0",
               core_cmd, busy);
    end
  endtask

  task automatic test_write();
    bit ok;
    int p;
    logic b;
    logic [7:0] got;
    logic [7:0] exp_b[3];
    int bad;
    exp_b[0] = 8'h3C;
    exp_b[1] = 8'h5A;
    exp_b[2] = 8'hA5;
    rxq.delete();
    repeat (3) rxq.push_back(1'b0);
    launch(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, LW'(3), 32'h00A5_5A3C);
    wait_done(ok, p, b);
    checks++;
    if (!ok || p != 1) begin
      errors++;
      $display("FAIL wr_cmd_ack: done=%0d pulses=%0d want 1/1", ok, p);
    end
    checks++;
    if (b !== 1'b0) begin
      errors++;
      $display("FAIL wr_busy_at_ack: busy=%b want 0", b);
    end
    checks++;
    if (logc.size() != 29) begin
      errors++;
      $display("FAIL wr_len: cmds=%0d want 29", logc.size());
    end else begin
      checks++;
      if (logc[0] !== START || logc[28] !== STOP) begin
        errors++;
        $display("FAIL wr_frame: first=%b last=%b want 0001/0010",
                 logc[0], logc[28]);
      end
      for (int k = 0; k < 3; k++) begin
        got = '0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
          got = {got[6:0], logt[1 + 9*k + i]};
          if (logc[1 + 9*k + i] !== WR) bad++;
        end
        if (logc[9 + 9*k] !== RD) bad++;
        checks++;
        if (got !== exp_b[k] || bad != 0) begin
          errors++;
          $display("FAIL wr_byte%0d: got=%h badcmd=%0d want %h/0",
                   k, got, bad, exp_b[k]);
        end
      end
    end
    checks++;
    if (byte_cnt !== LW'(3) || nack !== 1'b0 || ack_out !== 1'b0) begin
      errors++;
      $display("FAIL wr_status: cnt=%0d nack=%b aout=%b want 3/0/0",
               byte_cnt, nack, ack_out);
    end
  endtask

  task automatic test_write_nack();
    bit ok;
    int p;
    logic b;
    rxq.delete();
    rxq.push_back(1'b0);
    rxq.push_back(1'b1);
    launch(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, LW'(3), 32'h00A5_5A3C);
    wait_done(ok, p, b);
    checks++;
    if (!ok || p != 1) begin
      errors++;
      $display("FAIL nack_cmd_ack: done=%0d pulses=%0d want 1/1", ok, p);
    end
    checks++;
    if (logc.size() != 20) begin
      errors++;
      $display("FAIL nack_len: cmds=%0d want 20", logc.size());
    end else begin
      checks++;
      if (logc[18] !== RD || logc[19] !== STOP) begin
        errors++;
        $display("FAIL nack_tail: %b %b want 1000 0010", logc[18], logc[19]);
      end
    end
    checks++;
    if (nack !== 1'b1 || byte_cnt !== LW'(2) || ack_out !== 1'b1) begin
      errors++;
      $display("FAIL nack_status: nack=%b cnt=%0d aout=%b want 1/2/1",
               nack, byte_cnt, ack_out);
    end
  endtask

  task automatic test_read();
    bit ok;
    int p;
    logic b;
    logic [7:0] d0;
    logic [7:0] d1;
    d0 = 8'h81;
    d1 = 8'h7E;
    rxq.delete();
    for (int i = 7; i >= 0; i--) rxq.push_back(d0[i]);
    for (int i = 7; i >= 0; i--) rxq.push_back(d1[i]);
    launch(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, LW'(2), '0);
    wait_done(ok, p, b);
    checks++;
    if (!ok || p != 1) begin
      errors++;
      $display("FAIL rd_cmd_ack: done=%0d pulses=%0d want 1/1", ok, p);
    end
    checks++;
    if (logc.size() != 18) begin
      errors++;
      $display("FAIL rd_len: cmds=%0d want 18", logc.size());
    end else begin
      checks++;
      if (logc[8] !== WR || logt[8] !== 1'b0 ||
          logc[17] !== WR || logt[17] !== 1'b1) begin
        errors++;
        $display("FAIL rd_master_ack: %b/%b %b/%b want 0100/0 0100/1",
                 logc[8], logt[8], logc[17], logt[17]);
      end
    end
    checks++;
    if (dout !== 32'h0000_7E81) begin
      errors++;
      $display("FAIL rd_dout: got=%h want 00007e81", dout);
    end
    checks++;
    if (byte_cnt !== LW'(2) || ack_out !== 1'b1 || nack !== 1'b0) begin
      errors++;
      $display("FAIL rd_status: cnt=%0d aout=%b nack=%b want 2/1/0",
               byte_cnt, ack_out, nack);
    end
  endtask

  task automatic test_arb_loss();
    bit ok;
    int p;
    int n;
    logic b;
    rxq.delete();
    repeat (8) rxq.push_back(1'b1);
    launch(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, LW'(1), '0);
    n = 0;
    while (logc.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (logc.size() < 4) begin
      errors++;
      $display("FAIL al_reach_bit4: cmds=%0d want 4", logc.size());
    end
    i2c_al = 1'b1;
    @(negedge clk);
    i2c_al = 1'b0;
    checks++;
    if (core_cmd !== NOP || busy !== 1'b0 || byte_cnt !== '0) begin
      errors++;
      $display("FAIL al_abort: cmd=%b busy=%b cnt=%0d want 0000/0/0",
               core_cmd, busy, byte_cnt);
    end
    p = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ack) p++;
    end
    checks++;
    if (p != 0) begin
      errors++;
      $display("FAIL al_no_cmd_ack: pulses=%0d want 0", p);
    end
    rxq.delete();
    launch(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, LW'(1), '0);
    wait_done(ok, p, b);
    checks++;
    if (!ok || p != 1 || logc.size() != 1) begin
      errors++;
      $display("FAIL al_stop_only: done=%0d pulses=%0d cmds=%0d want 1/1/1",
               ok, p, logc.size());
    end else begin
      checks++;
      if (logc[0] !== STOP) begin
        errors++;
        $display("FAIL al_stop_cmd: got=%b want 0010", logc[0]);
      end
    end
  endtask

  task automatic test_len_boundary();
    bit ok;
    int p;
    logic b;
    rxq.delete();
    rxq.push_back(1'b0);
    launch(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LW'(0), 32'hFFFF_FFC3);
    wait_done(ok, p, b);
    checks++;
    if (!ok || p != 1 || logc.size() != 9 || byte_cnt !== LW'(1)) begin
      errors++;
      $display("FAIL len0: done=%0d pulses=%0d cmds=%0d cnt=%0d want 1/1/9/1",
               ok, p, logc.size(), byte_cnt);
    end
    rxq.delete();
    repeat (4) rxq.push_back(1'b0);
    launch(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LW'(7), 32'h1122_3344);
    wait_done(ok, p, b);
    checks++;
    if (!ok || p != 1 || logc.size() != 36 || byte_cnt !== LW'(4)) begin
      errors++;
      $display("FAIL len7_clamp: done=%0d pulses=%0d cmds=%0d cnt=%0d want 1/1/36/4",
               ok, p, logc.size(), byte_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_write_nack();
    test_read();
    test_arb_loss();
    test_len_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
